// File: rtl/csi2_packetizer.sv
// csi2_packetizer: RAW10 pixel stream to CSI-2 byte-level packet signals.
// Ports: clock_in/reset_n_in; frame_valid_in, x_size_in, pixel_* handshake in;
// payload_out/payload_en_out, sp_en_out, lp_av_en_out, dt_out, wc_out,
// crc_out/crc_valid_out, abort_out out. All outputs registered.
module csi2_packetizer #(
  parameter logic [5:0] DATA_TYPE = 6'h2B,
  parameter int         LINE_GAP  = 2
) (
  input  logic        clock_in,
  input  logic        reset_n_in,
  input  logic        frame_valid_in,
  input  logic [10:0] x_size_in,
  input  logic [9:0]  pixel_data_in,
  input  logic        pixel_valid_in,
  output logic        pixel_ready_out,
  output logic [7:0]  payload_out,
  output logic        payload_en_out,
  output logic        sp_en_out,
  output logic        lp_av_en_out,
  output logic [5:0]  dt_out,
  output logic [15:0] wc_out,
  output logic [15:0] crc_out,
  output logic        crc_valid_out,
  output logic        abort_out
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FS        = 3'd1;
  localparam logic [2:0] S_LINE_WAIT = 3'd2;
  localparam logic [2:0] S_HEADER    = 3'd3;
  localparam logic [2:0] S_PAYLOAD   = 3'd4;
  localparam logic [2:0] S_CRC       = 3'd5;
  localparam logic [2:0] S_GAP       = 3'd6;
  localparam logic [2:0] S_FE        = 3'd7;

  localparam logic [3:0] GAP_LAST = 4'(LINE_GAP - 1);

  // Slot 5 is the cycle the last LSB byte is on the bus;
  // slot 6 is the cycle abort_out is shown, FE follows.
  localparam logic [2:0] SLOT_LSB   = 3'd4;
  localparam logic [2:0] SLOT_TAIL  = 3'd5;
  localparam logic [2:0] SLOT_ABORT = 3'd6;

  logic [2:0]  state;
  logic [8:0]  groups;
  logic [8:0]  grp_cnt;
  logic [2:0]  slot;
  logic [7:0]  lsb;
  logic [15:0] crc;
  logic [15:0] frame_number;
  logic [3:0]  gap_cnt;

  logic        accept;
  logic        last_grp;
  logic [7:0]  msb;
  logic [11:0] wc_line;
  logic        unused;

  assign accept   = pixel_valid_in & pixel_ready_out;
  assign last_grp = (grp_cnt == groups - 9'd1);
  assign msb      = pixel_data_in[9:2];
  assign wc_line  = {3'd0, groups} * 12'd5;
  assign unused   = ^x_size_in[1:0];

  function automatic logic [15:0] crc_byte(
    input logic [15:0] c,
    input logic [7:0]  d
  );
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'h8408;
      else             r = r >> 1;
    end
    return r;
  endfunction

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state           <= S_IDLE;
      groups          <= '0;
      grp_cnt         <= '0;
      slot            <= '0;
      lsb             <= '0;
      crc             <= 16'hFFFF;
      frame_number    <= 16'd1;
      gap_cnt         <= '0;
      pixel_ready_out <= 1'b0;
      payload_out     <= '0;
      payload_en_out  <= 1'b0;
      sp_en_out       <= 1'b0;
      lp_av_en_out    <= 1'b0;
      dt_out          <= '0;
      wc_out          <= '0;
      crc_out         <= '0;
      crc_valid_out   <= 1'b0;
      abort_out       <= 1'b0;
    end else begin
      sp_en_out      <= 1'b0;
      lp_av_en_out   <= 1'b0;
      payload_en_out <= 1'b0;
      crc_valid_out  <= 1'b0;
      abort_out      <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (frame_valid_in) begin
            groups    <= x_size_in[10:2];
            sp_en_out <= 1'b1;
            dt_out    <= 6'h00;
            wc_out    <= frame_number;
            state     <= S_FS;
          end
        end
        S_FS: state <= S_LINE_WAIT;
        S_LINE_WAIT: begin
          if (!frame_valid_in) begin
            sp_en_out <= 1'b1;
            dt_out    <= 6'h01;
            wc_out    <= frame_number;
            state     <= S_FE;
          end else if (pixel_valid_in) begin
            lp_av_en_out <= 1'b1;
            dt_out       <= DATA_TYPE;
            wc_out       <= {4'd0, wc_line};
            crc          <= 16'hFFFF;
            state        <= S_HEADER;
          end
        end
        S_HEADER: begin
          slot    <= '0;
          grp_cnt <= '0;
          if (groups == 9'd0) begin
            crc_valid_out <= 1'b1;
            crc_out       <= crc;
            state         <= S_CRC;
          end else begin
            pixel_ready_out <= 1'b1;
            state           <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (slot <= SLOT_LSB && !frame_valid_in) begin
            abort_out       <= 1'b1;
            pixel_ready_out <= 1'b0;
            slot            <= SLOT_ABORT;
          end else begin
            case (slot)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                if (accept) begin
                  payload_out    <= msb;
                  payload_en_out <= 1'b1;
                  crc            <= crc_byte(crc, msb);
                  lsb[{slot[1:0], 1'b0} +: 2] <= pixel_data_in[1:0];
                  if (slot == 3'd3) pixel_ready_out <= 1'b0;
                  slot <= slot + 3'd1;
                end
              end
              SLOT_LSB: begin
                payload_out    <= lsb;
                payload_en_out <= 1'b1;
                crc            <= crc_byte(crc, lsb);
                if (last_grp) begin
                  slot <= SLOT_TAIL;
                end else begin
                  grp_cnt         <= grp_cnt + 9'd1;
                  slot            <= 3'd0;
                  pixel_ready_out <= 1'b1;
                end
              end
              SLOT_TAIL: begin
                crc_valid_out <= 1'b1;
                crc_out       <= crc;
                state         <= S_CRC;
              end
              SLOT_ABORT: begin
                sp_en_out <= 1'b1;
                dt_out    <= 6'h01;
                wc_out    <= frame_number;
                state     <= S_FE;
              end
              default: slot <= 3'd0;
            endcase
          end
        end
        S_CRC: begin
          gap_cnt <= '0;
          state   <= S_GAP;
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) state <= S_LINE_WAIT;
          else gap_cnt <= gap_cnt + 4'd1;
        end
        S_FE: begin
          frame_number <= (frame_number == 16'hFFFF) ?
                          16'd1 : frame_number + 16'd1;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csi2_packetizer.sv
// tb_csi2_packetizer: scoreboard bench for csi2_packetizer.
// Expected packet events come from a frame/line model; a monitor pops them.
module tb_csi2_packetizer;

  logic        clock_in = 1'b0;
  logic        reset_n_in = 1'b0;
  logic        frame_valid_in = 1'b0;
  logic [10:0] x_size_in = '0;
  logic [9:0]  pixel_data_in = '0;
  logic        pixel_valid_in = 1'b0;
  logic        pixel_ready_out;
  logic [7:0]  payload_out;
  logic        payload_en_out;
  logic        sp_en_out;
  logic        lp_av_en_out;
  logic [5:0]  dt_out;
  logic [15:0] wc_out;
  logic [15:0] crc_out;
  logic        crc_valid_out;
  logic        abort_out;

  csi2_packetizer dut (
    .clock_in        (clock_in),
    .reset_n_in      (reset_n_in),
    .frame_valid_in  (frame_valid_in),
    .x_size_in       (x_size_in),
    .pixel_data_in   (pixel_data_in),
    .pixel_valid_in  (pixel_valid_in),
    .pixel_ready_out (pixel_ready_out),
    .payload_out     (payload_out),
    .payload_en_out  (payload_en_out),
    .sp_en_out       (sp_en_out),
    .lp_av_en_out    (lp_av_en_out),
    .dt_out          (dt_out),
    .wc_out          (wc_out),
    .crc_out         (crc_out),
    .crc_valid_out   (crc_valid_out),
    .abort_out       (abort_out)
  );

  always #5 clock_in = ~clock_in;

  localparam int K_FS = 0, K_FE = 1, K_HDR = 2;
  localparam int K_BYTE = 3, K_CRC = 4, K_ABT = 5;

  typedef struct {
    int          kind;
    logic [15:0] val;
    int          need;
  } ev_t;

  ev_t         exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] fn = 16'd1;
  bit          sb_on = 1'b1;
  logic [9:0]  fpx [0:3][0:63];

  task automatic push(input int k, input logic [15:0] v, input int nd);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.need = nd;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic pop_ev(input int k, output ev_t e, output bit ok);
    e.kind = -1;
    e.val  = '0;
    e.need = 0;
    ok     = 1'b0;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL sb_empty: got event kind %0d want none", k);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k) begin
        bad++;
        $display("FAIL sb_kind: got kind %0d want %0d", k, e.kind);
      end else begin
        ok = 1'b1;
      end
    end
  endtask

  function automatic logic [15:0] next_fn(input logic [15:0] f);
    return (f == 16'hFFFF) ? 16'd1 : f + 16'd1;
  endfunction

  // Monitor: every strobe the DUT shows must match the queue head.
  initial begin
    int         bidx;
    bit         pacc, pbyte, plp, ok;
    logic [9:0] ppx;
    ev_t        e;
    bidx = 0; pacc = 0; pbyte = 0; plp = 0; ppx = '0;
    forever begin
      @(negedge clock_in);
      if (!sb_on) begin
        pacc = 0; pbyte = 0; plp = 0;
      end else begin
        if (pacc) begin
          chk("acc_byte_en", 32'(payload_en_out), 1);
          if (payload_en_out)
            chk("acc_byte_val", 32'(payload_out), 32'(ppx[9:2]));
        end
        if (sp_en_out) begin
          pop_ev((dt_out == 6'h01) ? K_FE : K_FS, e, ok);
          if (ok) begin
            chk("sp_dt", 32'(dt_out), (e.kind == K_FE) ? 1 : 0);
            chk("sp_wc", 32'(wc_out), 32'(e.val));
          end
        end
        if (lp_av_en_out) begin
          pop_ev(K_HDR, e, ok);
          if (ok) begin
            chk("hdr_dt", 32'(dt_out), 32'h2B);
            chk("hdr_wc", 32'(wc_out), 32'(e.val));
          end
          bidx = 0;
        end
        if (payload_en_out) begin
          pop_ev(K_BYTE, e, ok);
          if (ok) chk("byte", 32'(payload_out), 32'(e.val));
          if (bidx % 5 == 3)
            chk("slot4_ready", 32'(pixel_ready_out), 0);
          bidx++;
        end
        if (crc_valid_out) begin
          pop_ev(K_CRC, e, ok);
          if (ok) begin
            chk("crc", 32'(crc_out), 32'(e.val));
            chk("crc_timing", (e.need == 1) ? 32'(pbyte) : 32'(plp), 1);
          end
        end
        if (abort_out) pop_ev(K_ABT, e, ok);
        pacc  = pixel_valid_in && pixel_ready_out;
        ppx   = pixel_data_in;
        pbyte = payload_en_out;
        plp   = lp_av_en_out;
      end
    end
  end

  task automatic tick;
    @(posedge clock_in);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 2000) begin
      tick();
      c++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout: got %0d pending want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Line model: header, RAW10 bytes in order, then CRC (or abort + FE).
  // CRC is run in its non-reflected form (poly 1021, bit-reversed I/O).
  task automatic push_line(input int l, input int g, input int stop_at);
    logic [15:0] s;
    logic [15:0] r;
    logic [7:0]  b;
    logic [9:0]  p;
    bit          fb;
    int          idx;
    s = 16'hFFFF;
    push(K_HDR, 16'(g * 5), 0);
    for (int gi = 0; gi < g; gi++) begin
      for (int k = 0; k < 5; k++) begin
        idx = 4 * gi + k;
        if (stop_at >= 0 && k < 4 && idx >= stop_at) break;
        if (stop_at >= 0 && k == 4 && 4 * gi + 4 >= stop_at) break;
        if (k < 4) begin
          p = fpx[l][idx];
          b = p[9:2];
        end else begin
          b = '0;
          for (int j = 0; j < 4; j++) begin
            p = fpx[l][4 * gi + j];
            b = b | (8'(p[1:0]) << (2 * j));
          end
        end
        push(K_BYTE, 16'(b), 0);
        for (int i = 0; i < 8; i++) begin
          fb = s[15] ^ b[i];
          s  = {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
      end
    end
    if (stop_at < 0) begin
      for (int i = 0; i < 16; i++) r[i] = s[15 - i];
      push(K_CRC, r, (g > 0) ? 1 : 2);
    end else begin
      push(K_ABT, 16'd0, 0);
      push(K_FE, fn, 0);
      fn = next_fn(fn);
    end
  endtask

  task automatic drive_line(input int l, input int npx, input int bub,
                            input int stop_at);
    int idx, c;
    idx = 0;
    c = 0;
    while (idx < npx && idx != stop_at && c < 3000) begin
      pixel_valid_in = ($urandom_range(99) < bub) ? 1'b0 : 1'b1;
      pixel_data_in  = fpx[l][idx];
      @(negedge clock_in);
      if (pixel_valid_in && pixel_ready_out) idx++;
      tick();
      c++;
    end
    pixel_valid_in = 1'b0;
    if (stop_at >= 0) frame_valid_in = 1'b0;
    total++;
    if (c >= 3000) begin
      bad++;
      $display("FAIL drive_timeout: got %0d pixels want %0d", idx, npx);
    end
  endtask

  task automatic zero_line;
    int c;
    bit seen;
    c = 0;
    seen = 0;
    pixel_valid_in = 1'b1;
    while (!seen && c < 100) begin
      @(negedge clock_in);
      seen = lp_av_en_out;
      c++;
    end
    tick();
    pixel_valid_in = 1'b0;
    chk("zero_line_hdr_seen", 32'(seen), 1);
  endtask

  task automatic run_frame(input int nlines, input int xsize, input int bub,
                           input int stop_at, input bit regen);
    int g, npx;
    g   = (xsize % 2048) / 4;
    npx = g * 4;
    if (regen)
      for (int l = 0; l < 4; l++)
        for (int i = 0; i < 64; i++)
          fpx[l][i] = 10'($urandom_range(1023));
    push(K_FS, fn, 0);
    x_size_in      = 11'(xsize);
    frame_valid_in = 1'b1;
    if (nlines == 0) repeat (4) tick();
    for (int l = 0; l < nlines; l++) begin
      push_line(l, g, stop_at);
      if (npx == 0) zero_line();
      else drive_line(l, npx, bub, stop_at);
      wait_drain("line");
      if (stop_at >= 0) break;
    end
    if (stop_at < 0) begin
      push(K_FE, fn, 0);
      fn = next_fn(fn);
      frame_valid_in = 1'b0;
      wait_drain("frame_end");
    end
    repeat (3) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int px0 [0:7];
    px0 = '{10'h3FF, 10'h000, 10'h155, 10'h2AA,
            10'h001, 10'h002, 10'h003, 10'h004};
    repeat (3) tick();
    chk("rst_payload_en", 32'(payload_en_out), 0);
    chk("rst_ready", 32'(pixel_ready_out), 0);
    chk("rst_sp", 32'(sp_en_out), 0);
    chk("rst_lp", 32'(lp_av_en_out), 0);
    chk("rst_crc_valid", 32'(crc_valid_out), 0);
    chk("rst_abort", 32'(abort_out), 0);
    chk("rst_dt", 32'(dt_out), 0);
    chk("rst_wc", 32'(wc_out), 0);
    chk("rst_crc", 32'(crc_out), 0);
    chk("rst_payload", 32'(payload_out), 0);
    reset_n_in = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 8; i++) fpx[0][i] = 10'(px0[i]);
    run_frame(1, 8, 0, -1, 1'b0);

    run_frame(3, $urandom_range(4, 48), 0, -1, 1'b1);
    run_frame(1, $urandom_range(4, 48), 0, -1, 1'b1);

    run_frame(2, 20, 40, -1, 1'b1);
    run_frame(2, 20, 0, -1, 1'b0);
    run_frame(2, 47, 60, -1, 1'b1);

    run_frame(1, 16, 0, 5, 1'b1);
    run_frame(1, 8, 0, -1, 1'b1);

    run_frame(1, 3, 0, -1, 1'b1);

    @(negedge clock_in);
    force dut.frame_number = 16'hFFFF;
    tick();
    release dut.frame_number;
    fn = 16'hFFFF;
    run_frame(0, 8, 0, -1, 1'b1);
    run_frame(0, 8, 0, -1, 1'b1);
    run_frame(1, 12, 20, -1, 1'b1);

    sb_on          = 1'b0;
    x_size_in      = 11'd16;
    frame_valid_in = 1'b1;
    pixel_valid_in = 1'b1;
    pixel_data_in  = 10'h2C5;
    repeat (7) tick();
    @(negedge clock_in);
    chk("pre_reset_payload_en", 32'(payload_en_out), 1);
    tick();
    reset_n_in = 1'b0;
    #1;
    chk("mid_rst_payload_en", 32'(payload_en_out), 0);
    chk("mid_rst_ready", 32'(pixel_ready_out), 0);
    chk("mid_rst_payload", 32'(payload_out), 0);
    chk("mid_rst_wc", 32'(wc_out), 0);
    chk("mid_rst_dt", 32'(dt_out), 0);
    frame_valid_in = 1'b0;
    pixel_valid_in = 1'b0;
    repeat (2) tick();
    reset_n_in = 1'b1;
    exp_q.delete();
    fn = 16'd1;
    tick();
    sb_on = 1'b1;
    run_frame(1, 8, 20, -1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
